// File: rtl/driver_switches_if.sv
// CPU bridge bus seen by the switch input peripheral: word select, write data/enable,
// read data and the interrupt request.
interface driver_switches_if;
  logic [1:0]  Addr;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] RD;
  logic        irq;

  modport master (output Addr, output DIn, output WE, input RD, input irq);
  modport slave  (input Addr, input DIn, input WE, output RD, output irq);
endinterface

// File: rtl/driver_switches.sv
// Switch/button input peripheral: 2-flop synchroniser, two-sample debounce on a periodic
// tick, sticky change flags with write-1-to-clear, and a maskable registered interrupt.
module driver_switches #(
  parameter int unsigned DEBOUNCE_TICKS = 500000,
  parameter int unsigned TICK_W         = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        sw_in,
  driver_switches_if.slave   bus
);

  localparam int unsigned DW = 32;
  localparam logic [1:0]  A_STABLE = 2'd0;
  localparam logic [1:0]  A_FLAGS  = 2'd1;
  localparam logic [1:0]  A_MASK   = 2'd2;
  localparam logic [1:0]  A_CTRL   = 2'd3;

  logic [DW-1:0]     sync1, sync2, sample_q, stable, flags, mask;
  logic [1:0]        ctrl;
  logic [TICK_W-1:0] tick_cnt;
  logic              irq_q;

  logic              tick;
  logic [DW-1:0]     chg, stable_next, set_v, clr_v, flags_next;
  logic              irq_en, edge_sel;

  assign irq_en   = ctrl[0];
  assign edge_sel = ctrl[1];
  assign tick     = (tick_cnt == TICK_W'(DEBOUNCE_TICKS - 1));

  // A bit changes only when two consecutive tick samples agree and differ from stable.
  always_comb begin
    chg         = '0;
    clr_v       = '0;
    if (tick) chg = (sync2 ~^ sample_q) & (sync2 ^ stable);
    stable_next = stable ^ chg;
    set_v       = chg & ({DW{~edge_sel}} | stable_next);
    if (bus.WE && (bus.Addr == A_FLAGS)) clr_v = bus.DIn;
    flags_next  = set_v | (flags & ~clr_v);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      sample_q <= '0;
      stable   <= '0;
      flags    <= '0;
      mask     <= '0;
      ctrl     <= '0;
      tick_cnt <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync1    <= sw_in;
      sync2    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      if (tick) sample_q <= sync2;
      stable   <= stable_next;
      flags    <= flags_next;
      if (bus.WE && (bus.Addr == A_MASK)) mask <= bus.DIn;
      if (bus.WE && (bus.Addr == A_CTRL)) ctrl <= bus.DIn[1:0];
      irq_q    <= irq_en & (|(flags & mask));
    end
  end

  assign bus.irq = irq_q;

  // Read mux is combinational from Addr and forced to zero while in reset.
  always_comb begin
    bus.RD = '0;
    if (!reset) begin
      case (bus.Addr)
        A_STABLE: bus.RD = stable;
        A_FLAGS:  bus.RD = flags;
        A_MASK:   bus.RD = mask;
        A_CTRL:   bus.RD = {30'd0, ctrl};
        default:  bus.RD = '0;
      endcase
    end
  end

endmodule

// File: doc/driver_switches.md
Name: driver_switches

Overview:
- Memory-mapped input peripheral: the read-direction counterpart to the LED output driver on the CPU bridge bus.
- Synchronises and debounces 32 external switch/button lines.
- Latches per-bit change events in sticky flags.
- Raises a maskable interrupt request to the CPU.
- Software reads state and flags through the bridge; writes program the mask/enable and clear flags.

Parameters:
- DEBOUNCE_TICKS, 500000, clk cycles between debounce samples (≥2).
- TICK_W, 20, width of the sample-interval counter (2^TICK_W ≥ DEBOUNCE_TICKS).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sw_in  input  32  raw asynchronous switch/button levels.
- Addr  input  2  word select (bus address bits [3:2]).
- DIn  input  32  write data from bridge.
- WE  input  1  write enable, one cycle per write.
- RD  output  32  read data, combinational from Addr.
- irq  output  1  registered interrupt request, active-high.

Behaviour:
Reset (clk edge with reset=1):
- sync1, sync2, sample_q, stable, flags and mask cleared to 0; ctrl cleared to 0.
- tick_cnt cleared to 0; irq cleared to 0.
- RD = 0 whenever reset=1, regardless of Addr.

Input path:
- sync1 <= sw_in; sync2 <= sync1 every cycle.

Sample tick:
- tick_cnt counts 0..DEBOUNCE_TICKS-1, then wraps to 0.
- tick = (tick_cnt == DEBOUNCE_TICKS-1), asserted for one cycle per interval.

Debounce, on each tick edge:
- sample_q <= sync2.
- For each bit i: if sync2[i] == sample_q[i] and sync2[i] != stable[i], then stable[i] <= sync2[i] and chg[i] = 1. Otherwise stable[i] is held and chg[i] = 0.
- chg = 0 on non-tick cycles.
- Result: a clean level step seen on sync2 before tick k updates stable at tick k+1.
- A glitch shorter than one tick interval never updates stable.

Register map, read via RD:
- Addr 0: stable (read-only; writes ignored).
- Addr 1: flags (sticky change flags).
- Addr 2: mask (read/write).
- Addr 3: ctrl, zero-extended. ctrl[0] = irq_en; ctrl[1] = edge_sel (0: any change; 1: rising only).

Flag update, per bit, each cycle:
- set_i = chg[i] & (~edge_sel | stable_next[i]).
- clr_i = WE & (Addr==1) & DIn[i] (write-1-to-clear).
- flags[i] <= set_i ? 1 : (clr_i ? 0 : flags[i]). Set wins over a simultaneous clear.

Writes:
- Addr 2: mask <= DIn.
- Addr 3: ctrl <= DIn[1:0].
- Single-cycle; the new value is visible on RD the next cycle.

Interrupt:
- irq <= irq_en & |(flags & mask), registered.
- irq asserts 1 cycle after the flag-setting edge and deasserts 1 cycle after the clearing write.
- irq stays level while any unmasked flag remains set.
- Changing mask or irq_en re-evaluates irq on the next edge.

Boundary conditions:
- Input changes between samples are caught at the next tick.
- A bit toggling every tick interval never stabilises (no flag).
- Reset mid-debounce discards all partial samples.
- After reset, inputs held high produce stable=1 and, with edge_sel=0, set their flags. This is the intended power-up behaviour; software clears the flags after boot.

Test Plan:
1. DEBOUNCE_TICKS=4. Reset, sw_in=0 → RD=0 on all Addr; irq=0. Release reset, hold 10 cycles → stable=0, flags=0.
2. sw_in=0x0000_0005 held → stable=0x5 at the second tick after sync2 changes; read Addr1 → 0x5. Write Addr1 DIn=0x1 → flags=0x4.
3. Pulse sw_in[3]=1 for 2 cycles (shorter than a tick interval) → stable[3]=0, flags[3]=0.
4. mask=0x4, ctrl=0x1, flags[2] set → irq=1 one cycle later. Write Addr1 DIn=0x4 → irq=0 one cycle after the write. With mask=0, a set flag leaves irq=0.
5. ctrl=0x3 (rising only). Drive sw_in[0] 1→0 → stable[0]=0, flags[0] stays 0. Drive 0→1 → flags[0]=1.
6. A clear write to Addr1 bit 7 lands on the same cycle chg[7] sets it → flags[7]=1. Assert reset mid-operation → all registers 0 and RD=0 during reset.
